mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Data-memory access controller: one load/store per command, IDLE -> BUSY -> DONE.
// Latency: bus_req one cycle after accept; ld_valid/err one cycle after bus_ack or abort.
// Backpressure: stall holds the pipeline while a command is accepted or in flight; low in DONE.
module mem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_en,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Last BUSY-cycle count before the access is abandoned.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_ld_data;
  logic        r_ld_valid;
  logic        r_err;

  logic        w_misaligned;
  logic        w_timeout;

  assign w_misaligned = (cmd_addr[1:0] != 2'b00);
  assign w_timeout    = (r_cnt == LP_CNT_LAST);

  // Hold upstream while a command is being accepted or is on the bus; DONE releases it.
  always_comb begin
    stall = ((r_state == ST_IDLE) && cmd_en) || (r_state == ST_BUSY);
  end

  // Access sequencer with registered bus and completion outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_wdata <= 32'd0;
      r_ld_data   <= 32'd0;
      r_ld_valid  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ld_valid <= 1'b0;
          r_err      <= 1'b0;
          if (cmd_en) begin
            if (w_misaligned) begin
              // Misaligned: never touches the bus, reports the abort from DONE.
              r_state <= ST_DONE;
              r_err   <= 1'b1;
            end else begin
              r_state     <= ST_BUSY;
              r_cnt       <= 8'd0;
              r_bus_req   <= 1'b1;
              r_bus_we    <= cmd_wr;
              r_bus_addr  <= cmd_addr;
              r_bus_wdata <= cmd_wdata;
            end
          end
        end
        ST_BUSY: begin
          // Ack takes priority over the timeout when both land in the same cycle.
          if (bus_ack) begin
            r_state   <= ST_DONE;
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
            if (!r_bus_we) begin
              r_ld_data  <= bus_rdata;
              r_ld_valid <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state   <= ST_DONE;
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
            r_ld_data <= 32'd0;
            r_err     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          // The command still visible here is the one just served; always go back to IDLE.
          r_state    <= ST_IDLE;
          r_ld_valid <= 1'b0;
          r_err      <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_bus_req <= 1'b0;
          r_bus_we  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign ld_data   = r_ld_data;
  assign ld_valid  = r_ld_valid;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios plus randomized accesses checked against
// a transaction-level model (bus-request count, completion flags, load data).
`timescale 1ns/1ps
module tb_mem_ctrl;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        cmd_en;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        stall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] m_ld_data;   // model of the ld_data holding register

  mem_ctrl #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_en    (cmd_en),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .stall     (stall),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .err       (err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access: present the command in IDLE, answer the bus after ack_at BUSY
  // cycles (ack_at < 0 means never), and check the outcome in DONE. Returns on
  // the DONE cycle with the command inputs still held.
  task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] rdata, output int req_cyc);
    bit          mis, ok, done;
    int          exp_nreq, nreq;
    logic        exp_err, exp_lv;
    logic [31:0] exp_ld;
    mis      = (addr[1:0] != 2'b00);
    ok       = !mis && (ack_at >= 0) && (ack_at < TO);
    exp_nreq = mis ? 0 : (ok ? ack_at + 1 : TO);
    exp_err  = !ok;
    exp_lv   = ok && !wr;
    exp_ld   = mis ? m_ld_data : (ok ? (wr ? m_ld_data : rdata) : 32'd0);

    @(negedge clk);
    check("idle_ld_valid", ld_valid, 0);
    check("idle_err", err, 0);
    check("idle_bus_req", bus_req, 0);
    cmd_en    = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
    #1 check("accept_stall", stall, 1);

    nreq    = 0;
    done    = 0;
    req_cyc = -1;
    for (int c = 0; c < TO + 8 && !done; c++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1;
      end else begin
        check("busy_bus_req", bus_req, 1);
        if (nreq == 0) req_cyc = cyc;
        check("busy_bus_we", bus_we, wr);
        check("busy_bus_addr", bus_addr, addr);
        check("busy_bus_wdata", bus_wdata, wdata);
        if (nreq == ack_at) begin
          bus_ack   = 1'b1;
          bus_rdata = rdata;
        end else begin
          bus_ack   = 1'b0;
          bus_rdata = $urandom;
        end
        nreq++;
      end
    end
    check("done_reached", 32'(done), 1);
    check("req_cycles", 32'(nreq), 32'(exp_nreq));
    check("done_bus_req", bus_req, 0);
    check("done_ld_valid", ld_valid, exp_lv);
    check("done_err", err, exp_err);
    check("done_ld_data", ld_data, exp_ld);
    m_ld_data = exp_ld;
    // Ack noise during DONE must be ignored.
    bus_ack   = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
  endtask

  initial begin
    int c1, c2, cx, gap;
    logic        r_wr;
    logic [31:0] r_addr;
    int          r_ack;

    rst_n     = 1'b0;
    cmd_en    = 1'b1;
    cmd_wr    = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    m_ld_data = 32'h0;

    // Reset state: registered outputs cleared, stall follows cmd_en.
    repeat (2) @(negedge clk);
    check("rst_stall_en1", stall, 1);
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_ld_data", ld_data, 0);
    check("rst_ld_valid", ld_valid, 0);
    check("rst_err", err, 0);
    cmd_en = 1'b0;
    #1 check("rst_stall_en0", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_cmd_stall", stall, 0);

    // Load with ack on the second BUSY cycle.
    do_access(1'b0, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF, cx);
    cmd_en = 1'b0;
    @(negedge clk);
    check("load_pulse_len", ld_valid, 0);
    check("load_data_hold", ld_data, 32'hDEAD_BEEF);

    // Store with immediate ack.
    do_access(1'b1, 32'h0000_0020, 32'h1234_5678, 0, 32'h0, cx);
    cmd_en = 1'b0;

    // Misaligned address.
    do_access(1'b0, 32'h0000_0013, 32'h0, 0, 32'h0, cx);
    cmd_en = 1'b0;

    // Timeout with no ack, then ack exactly on the last allowed cycle.
    do_access(1'b0, 32'h0000_0030, 32'h0, -1, 32'h0, cx);
    cmd_en = 1'b0;
    do_access(1'b0, 32'h0000_0034, 32'h0, TO - 1, 32'hCAFE_F00D, cx);
    cmd_en = 1'b0;

    // Back-to-back loads with cmd_en held through DONE.
    do_access(1'b0, 32'h0000_0100, 32'h0, 0, 32'h1111_1111, c1);
    do_access(1'b0, 32'h0000_0104, 32'h0, 0, 32'h2222_2222, c2);
    check("b2b_spacing", 32'(c2 - c1), 3);
    cmd_en = 1'b0;

    // Reset during BUSY, then a stray ack.
    @(negedge clk);
    cmd_en   = 1'b1;
    cmd_wr   = 1'b0;
    cmd_addr = 32'h0000_0040;
    bus_ack  = 1'b0;
    @(negedge clk);
    check("rstmid_busy_req", bus_req, 1);
    rst_n  = 1'b0;
    cmd_en = 1'b0;
    @(negedge clk);
    check("rstmid_bus_req", bus_req, 0);
    check("rstmid_stall", stall, 0);
    check("rstmid_ld_valid", ld_valid, 0);
    check("rstmid_err", err, 0);
    check("rstmid_ld_data", ld_data, 0);
    m_ld_data = 32'h0;
    rst_n     = 1'b1;
    bus_ack   = 1'b1;
    bus_rdata = 32'hBAD0_BAD0;
    repeat (3) begin
      @(negedge clk);
      check("stray_ld_valid", ld_valid, 0);
      check("stray_err", err, 0);
      check("stray_bus_req", bus_req, 0);
    end
    bus_ack = 1'b0;

    // Randomized accesses against the transaction model.
    for (int n = 0; n < 60; n++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) r_addr[1:0] = 2'($urandom_range(1, 3));
      r_ack  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TO));
      do_access(r_wr, r_addr, $urandom, r_ack, $urandom, cx);
      gap = int'($urandom_range(0, 2));
      if (gap != 0) begin
        cmd_en = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    cmd_en = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
